// File: rtl/iomem_uart.sv
// iomem_uart: 8N1 UART responder on the SoC iomem bus with a 256-byte window.
// Provides one TX holding path, one RX holding register, sticky error flags and a baud divider.
module iomem_uart #(
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
    parameter logic [15:0] CLK_DIV   = 16'd868
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        iomem_valid,
    output logic        iomem_ready,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic [31:0] iomem_rdata,
    output logic        uart_tx,
    input  logic        uart_rx
);
    typedef enum logic {BUS_IDLE = 1'b0, BUS_ACK = 1'b1} bus_state_t;
    typedef enum logic [1:0] {T_IDLE = 2'd0, T_START = 2'd1, T_DATA = 2'd2, T_STOP = 2'd3} tx_state_t;
    typedef enum logic [1:0] {R_IDLE = 2'd0, R_START = 2'd1, R_DATA = 2'd2, R_STOP = 2'd3} rx_state_t;

    bus_state_t  bus_state_r, bus_next_s;
    tx_state_t   tx_state_r, tx_next_s;
    rx_state_t   rx_state_r, rx_next_s;

    logic        ready_r, tx_busy_r, uart_tx_r;
    logic [31:0] rdata_r, rd_mux_s;
    logic [15:0] div_r, div_wr_s, tx_div_r, tx_cnt_r, rx_div_r, rx_cnt_r;
    logic        ack_data_rd_r, ack_stat_rd_r, ack_div_wr_r, ack_tx_wr_r, rx_clr_ok_r;
    logic [7:0]  tx_shift_r, rx_shift_r, rx_byte_r;
    logic [2:0]  tx_bit_r, rx_bit_r;
    logic        rx_meta_r, rx_sync_r, rx_valid_r, rx_overrun_r, frame_err_r;
    logic        hit_s, is_read_s, off_data_s, off_stat_s, off_div_s, stall_s, accept_s, ack_s;
    logic        tx_tick_s, tx_go_s, tx_load_s, rx_tick_s, rx_done_s, rx_ferr_s, rd_pending_s;
    logic        unused_s;

    assign iomem_ready = ready_r;
    assign iomem_rdata = rdata_r;
    assign uart_tx     = uart_tx_r;
    assign unused_s    = ^iomem_wdata[31:16];

    // Request decode, read mux and shared strobes
    always_comb begin
        hit_s        = iomem_valid && (iomem_addr[31:8] == BASE_ADDR[31:8]);
        is_read_s    = (iomem_wstrb == 4'h0);
        off_data_s   = (iomem_addr[7:0] == 8'h00);
        off_stat_s   = (iomem_addr[7:0] == 8'h04);
        off_div_s    = (iomem_addr[7:0] == 8'h08);
        stall_s      = off_data_s && iomem_wstrb[0] && tx_busy_r;
        accept_s     = (bus_state_r == BUS_IDLE) && hit_s && !stall_s;
        ack_s        = (bus_state_r == BUS_ACK);
        tx_load_s    = accept_s && off_data_s && iomem_wstrb[0];
        rd_pending_s = (ack_s && ack_data_rd_r) || (accept_s && off_data_s && is_read_s);
        div_wr_s     = (iomem_wdata[15:0] < 16'd4) ? 16'd4 : iomem_wdata[15:0];
        tx_tick_s    = (tx_cnt_r == 16'd0);
        tx_go_s      = ack_s && ack_tx_wr_r;
        rx_tick_s    = (rx_cnt_r == 16'd0);
        rx_done_s    = (rx_state_r == R_STOP) && rx_tick_s && rx_sync_r;
        rx_ferr_s    = (rx_state_r == R_STOP) && rx_tick_s && !rx_sync_r;
        if (off_data_s) begin
            rd_mux_s = {24'd0, rx_byte_r};
        end else if (off_stat_s) begin
            rd_mux_s = {28'd0, frame_err_r, rx_overrun_r, rx_valid_r, tx_busy_r};
        end else if (off_div_s) begin
            rd_mux_s = {16'd0, div_r};
        end else begin
            rd_mux_s = 32'd0;
        end
    end

    // Bus FSM next state
    always_comb begin
        bus_next_s = BUS_IDLE;
        case (bus_state_r)
            BUS_IDLE: bus_next_s = accept_s ? BUS_ACK : BUS_IDLE;
            BUS_ACK:  bus_next_s = BUS_IDLE;
            default:  bus_next_s = BUS_IDLE;
        endcase
    end

    // Bus FSM state; read data is captured on accept so the ACK cycle presents it registered
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_state_r   <= BUS_IDLE;
            ready_r       <= 1'b0;
            rdata_r       <= 32'd0;
            ack_data_rd_r <= 1'b0;
            ack_stat_rd_r <= 1'b0;
            ack_div_wr_r  <= 1'b0;
            ack_tx_wr_r   <= 1'b0;
            rx_clr_ok_r   <= 1'b0;
        end else begin
            bus_state_r   <= bus_next_s;
            ready_r       <= accept_s;
            rdata_r       <= (accept_s && is_read_s) ? rd_mux_s : 32'd0;
            ack_data_rd_r <= accept_s && off_data_s && is_read_s;
            ack_stat_rd_r <= accept_s && off_stat_s && is_read_s;
            ack_div_wr_r  <= accept_s && off_div_s && (iomem_wstrb == 4'hF);
            ack_tx_wr_r   <= tx_load_s;
            rx_clr_ok_r   <= !rx_done_s;
        end
    end

    // Divider and status flags; a flag set always beats a read-clear, and only reported flags clear
    always_ff @(posedge clk) begin
        if (rst) begin
            div_r        <= CLK_DIV;
            rx_valid_r   <= 1'b0;
            rx_overrun_r <= 1'b0;
            frame_err_r  <= 1'b0;
        end else begin
            if (ack_s && ack_div_wr_r) begin
                div_r <= div_wr_s;
            end
            if (rx_done_s) begin
                rx_valid_r <= 1'b1;
            end else if (ack_s && ack_data_rd_r && rx_clr_ok_r) begin
                rx_valid_r <= 1'b0;
            end
            if (rx_done_s && rx_valid_r && !rd_pending_s) begin
                rx_overrun_r <= 1'b1;
            end else if (ack_s && ack_stat_rd_r && rdata_r[2]) begin
                rx_overrun_r <= 1'b0;
            end
            if (rx_ferr_s) begin
                frame_err_r <= 1'b1;
            end else if (ack_s && ack_stat_rd_r && rdata_r[3]) begin
                frame_err_r <= 1'b0;
            end
        end
    end

    // TX FSM next state
    always_comb begin
        tx_next_s = tx_state_r;
        case (tx_state_r)
            T_IDLE:  tx_next_s = tx_go_s ? T_START : T_IDLE;
            T_START: tx_next_s = tx_tick_s ? T_DATA : T_START;
            T_DATA:  tx_next_s = (tx_tick_s && (tx_bit_r == 3'd7)) ? T_STOP : T_DATA;
            T_STOP:  tx_next_s = tx_tick_s ? T_IDLE : T_STOP;
            default: tx_next_s = T_IDLE;
        endcase
    end

    // TX datapath: the divider is latched at frame start so DIV writes never disturb a frame
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_r <= T_IDLE;
            tx_busy_r  <= 1'b0;
            uart_tx_r  <= 1'b1;
            tx_shift_r <= 8'd0;
            tx_div_r   <= CLK_DIV;
            tx_cnt_r   <= 16'd0;
            tx_bit_r   <= 3'd0;
        end else begin
            tx_state_r <= tx_next_s;
            if (tx_load_s) begin
                tx_busy_r <= 1'b1;
            end else if ((tx_state_r == T_STOP) && tx_tick_s) begin
                tx_busy_r <= 1'b0;
            end
            case (tx_state_r)
                T_IDLE: begin
                    if (tx_go_s) begin
                        tx_shift_r <= iomem_wdata[7:0];
                        tx_div_r   <= div_r;
                        tx_cnt_r   <= div_r - 16'd1;
                        tx_bit_r   <= 3'd0;
                        uart_tx_r  <= 1'b0;
                    end
                end
                T_START: begin
                    if (tx_tick_s) begin
                        tx_cnt_r  <= tx_div_r - 16'd1;
                        uart_tx_r <= tx_shift_r[0];
                    end else begin
                        tx_cnt_r <= tx_cnt_r - 16'd1;
                    end
                end
                T_DATA: begin
                    if (tx_tick_s) begin
                        tx_cnt_r <= tx_div_r - 16'd1;
                        tx_bit_r <= tx_bit_r + 3'd1;
                        if (tx_bit_r == 3'd7) begin
                            uart_tx_r <= 1'b1;
                        end else begin
                            uart_tx_r  <= tx_shift_r[1];
                            tx_shift_r <= {1'b0, tx_shift_r[7:1]};
                        end
                    end else begin
                        tx_cnt_r <= tx_cnt_r - 16'd1;
                    end
                end
                T_STOP: begin
                    if (!tx_tick_s) begin
                        tx_cnt_r <= tx_cnt_r - 16'd1;
                    end
                end
                default: uart_tx_r <= 1'b1;
            endcase
        end
    end

    // RX FSM next state
    always_comb begin
        rx_next_s = rx_state_r;
        case (rx_state_r)
            R_IDLE:  rx_next_s = rx_sync_r ? R_IDLE : R_START;
            R_START: rx_next_s = rx_tick_s ? (rx_sync_r ? R_IDLE : R_DATA) : R_START;
            R_DATA:  rx_next_s = (rx_tick_s && (rx_bit_r == 3'd7)) ? R_STOP : R_DATA;
            R_STOP:  rx_next_s = rx_tick_s ? R_IDLE : R_STOP;
            default: rx_next_s = R_IDLE;
        endcase
    end

    // RX synchronizer and datapath; START waits half a bit so data is sampled at bit centre
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_r  <= 1'b1;
            rx_sync_r  <= 1'b1;
            rx_state_r <= R_IDLE;
            rx_shift_r <= 8'd0;
            rx_byte_r  <= 8'd0;
            rx_div_r   <= CLK_DIV;
            rx_cnt_r   <= 16'd0;
            rx_bit_r   <= 3'd0;
        end else begin
            rx_meta_r  <= uart_rx;
            rx_sync_r  <= rx_meta_r;
            rx_state_r <= rx_next_s;
            case (rx_state_r)
                R_IDLE: begin
                    if (!rx_sync_r) begin
                        rx_div_r <= div_r;
                        rx_cnt_r <= (div_r >> 1) - 16'd1;
                        rx_bit_r <= 3'd0;
                    end
                end
                R_START: begin
                    if (rx_tick_s) begin
                        rx_cnt_r <= rx_div_r - 16'd1;
                    end else begin
                        rx_cnt_r <= rx_cnt_r - 16'd1;
                    end
                end
                R_DATA: begin
                    if (rx_tick_s) begin
                        rx_cnt_r   <= rx_div_r - 16'd1;
                        rx_shift_r <= {rx_sync_r, rx_shift_r[7:1]};
                        rx_bit_r   <= rx_bit_r + 3'd1;
                    end else begin
                        rx_cnt_r <= rx_cnt_r - 16'd1;
                    end
                end
                R_STOP: begin
                    if (rx_tick_s) begin
                        if (rx_sync_r) begin
                            rx_byte_r <= rx_shift_r;
                        end
                    end else begin
                        rx_cnt_r <= rx_cnt_r - 16'd1;
                    end
                end
                default: rx_cnt_r <= 16'd0;
            endcase
        end
    end
endmodule

// File: tb/tb_iomem_uart.sv
// Scoreboard bench for iomem_uart: bus responses and TX frames are predicted from a register-level
// model of the UART and checked by independent monitor processes.
module tb_iomem_uart;
    localparam logic [31:0] BASE = 32'h0200_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        iomem_valid, iomem_ready, uart_tx, uart_rx;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr, iomem_wdata, iomem_rdata;

    iomem_uart dut (
        .clk(clk), .rst(rst),
        .iomem_valid(iomem_valid), .iomem_ready(iomem_ready), .iomem_wstrb(iomem_wstrb),
        .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata), .iomem_rdata(iomem_rdata),
        .uart_tx(uart_tx), .uart_rx(uart_rx)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] exp;
        bit          chk;
        bit          stat;
        bit          txwr;
        int          issue;
        int          div;
        logic [7:0]  txb;
    } bus_exp_t;

    typedef struct {
        int         start;
        int         div;
        logic [7:0] data;
    } tx_exp_t;

    bus_exp_t bus_q[$];
    tx_exp_t  tx_q[$];
    int       busy_until = -1000;

    // reference model of the programmer-visible state
    int         m_div = 868;
    logic [7:0] m_rx  = 8'd0;
    bit         m_valid = 1'b0, m_over = 1'b0, m_ferr = 1'b0;

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // bus monitor: pops the predicted response whenever the DUT acknowledges
    initial begin : bus_mon
        bus_exp_t    e;
        tx_exp_t     t;
        int          want;
        logic [31:0] expv;
        bit          prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst !== 1'b0) begin
                prev = 1'b0;
            end else begin
                if (iomem_ready === 1'b1 && prev) check(1'b0, "ready_back_to_back", 32'd1, 32'd0);
                if (iomem_ready === 1'b1) begin
                    if (bus_q.size() == 0) begin
                        check(1'b0, "unexpected_ready", 32'd1, 32'd0);
                    end else begin
                        e = bus_q.pop_front();
                        want = e.issue + 1;
                        if (e.txwr && (busy_until + 2 > want)) want = busy_until + 2;
                        check(cyc == want, "ack_cycle", cyc, want);
                        if (e.chk) begin
                            expv = e.exp;
                            if (e.stat && ((cyc - 1) <= busy_until)) expv[0] = 1'b1;
                            check(iomem_rdata === expv, "rdata", iomem_rdata, expv);
                        end
                        if (e.txwr) begin
                            busy_until = cyc + 10 * e.div;
                            t.start = cyc + 1;
                            t.div   = e.div;
                            t.data  = e.txb;
                            tx_q.push_back(t);
                        end
                    end
                end
                prev = (iomem_ready === 1'b1);
            end
        end
    end

    // TX monitor: every clock of a frame is compared with the ideal 8N1 waveform
    initial begin : tx_mon
        tx_exp_t    t;
        int         bad;
        int         n;
        logic [9:0] frame;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && uart_tx === 1'b0) begin
                if (tx_q.size() == 0) begin
                    check(1'b0, "tx_unexpected_frame", 32'd0, 32'd1);
                    n = 0;
                    while (uart_tx !== 1'b1 && n < 5000) begin
                        @(negedge clk);
                        n++;
                    end
                end else begin
                    t = tx_q.pop_front();
                    check(cyc == t.start, "tx_start_cycle", cyc, t.start);
                    frame = {1'b1, t.data, 1'b0};
                    bad = 0;
                    for (int k = 0; k < 10 * t.div; k++) begin
                        if (k > 0) @(negedge clk);
                        if (uart_tx !== frame[k / t.div]) bad++;
                    end
                    check(bad == 0, "tx_frame_bits", bad, {24'd0, t.data});
                    @(negedge clk);
                    check(uart_tx === 1'b1, "tx_idle_after_frame", {31'd0, uart_tx}, 32'd1);
                end
            end
        end
    end

    task automatic bus_op(input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] wdata,
                          input logic [31:0] exp, input bit chk, input bit stat);
        bus_exp_t e;
        bit       got;
        int       n;
        @(posedge clk); #1;
        iomem_valid = 1'b1;
        iomem_addr  = addr;
        iomem_wstrb = strb;
        iomem_wdata = wdata;
        e.exp   = exp;
        e.chk   = chk;
        e.stat  = stat;
        e.issue = cyc;
        e.div   = m_div;
        e.txwr  = (addr == BASE) && strb[0];
        e.txb   = wdata[7:0];
        bus_q.push_back(e);
        got = 1'b0;
        n = 0;
        while (!got && n < 3000) begin
            @(negedge clk);
            n++;
            if (iomem_ready === 1'b1) got = 1'b1;
        end
        if (!got) begin
            check(1'b0, "ready_timeout", addr, exp);
            bus_q.delete(bus_q.size() - 1);
        end
        @(posedge clk); #1;
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
        iomem_addr  = 32'd0;
        iomem_wdata = 32'd0;
    endtask

    task automatic rd(input logic [7:0] off, input logic [31:0] exp);
        bus_op(BASE | {24'd0, off}, 4'h0, 32'd0, exp, 1'b1, 1'b0);
    endtask

    task automatic rd_status();
        bus_op(BASE | 32'h4, 4'h0, 32'd0, {28'd0, m_ferr, m_over, m_valid, 1'b0}, 1'b1, 1'b1);
        m_over = 1'b0;
        m_ferr = 1'b0;
    endtask

    task automatic rd_data();
        bus_op(BASE, 4'h0, 32'd0, {24'd0, m_rx}, 1'b1, 1'b0);
        m_valid = 1'b0;
    endtask

    task automatic wr_div(input logic [31:0] v, input logic [3:0] strb);
        bus_op(BASE | 32'h8, strb, v, 32'd0, 1'b0, 1'b0);
        if (strb == 4'hF) m_div = (v[15:0] < 16'd4) ? 4 : int'(v[15:0]);
    endtask

    task automatic wr_tx(input logic [7:0] b);
        bus_op(BASE, 4'h1, {24'd0, b}, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic wait_tx_idle();
        while (cyc <= busy_until + 2) @(posedge clk);
    endtask

    task automatic send_rx(input logic [7:0] b, input bit stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        @(posedge clk); #1;
        for (int k = 0; k < 10; k++) begin
            uart_rx = f[k];
            repeat (m_div) @(posedge clk);
            #1;
        end
        uart_rx = 1'b1;
        repeat (m_div + 6) @(posedge clk);
        if (stop) begin
            if (m_valid) m_over = 1'b1;
            m_rx    = b;
            m_valid = 1'b1;
        end else begin
            m_ferr = 1'b1;
        end
    endtask

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int          bad;
        logic [31:0] v;
        logic [3:0]  s;
        logic [7:0]  off;
        rst = 1'b1;
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
        iomem_addr  = 32'd0;
        iomem_wdata = 32'd0;
        uart_rx     = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check(iomem_ready === 1'b0, "reset_ready", {31'd0, iomem_ready}, 32'd0);
        check(iomem_rdata === 32'd0, "reset_rdata", iomem_rdata, 32'd0);
        check(uart_tx === 1'b1, "reset_uart_tx", {31'd0, uart_tx}, 32'd1);
        rd(8'h08, 32'h0000_0364);
        rd_status();

        // TX at div 4, a DIV change mid-frame, then a stalled second write using the new divider
        wr_div(32'd4, 4'hF);
        rd(8'h08, 32'd4);
        wr_tx(8'h5A);
        rd_status();
        wr_div(32'd6, 4'hF);
        rd(8'h08, 32'd6);
        wr_tx(8'hC3);
        rd_status();
        wait_tx_idle();
        rd_status();

        // RX path, overrun and framing error
        wr_div(32'd8, 4'hF);
        send_rx(8'hA5, 1'b1);
        rd_status();
        rd_data();
        rd_status();
        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        send_rx(8'h33, 1'b0);
        rd_status();
        rd_status();
        rd_data();

        // out-of-window access is never acknowledged
        @(posedge clk); #1;
        iomem_valid = 1'b1;
        iomem_addr  = 32'h0300_0000;
        iomem_wstrb = 4'h0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (iomem_ready !== 1'b0 || iomem_rdata !== 32'd0) bad++;
        end
        check(bad == 0, "miss_no_ready", bad, 32'd0);
        @(posedge clk); #1;
        iomem_valid = 1'b0;
        iomem_addr  = 32'd0;

        wr_div(32'd2, 4'hF);
        rd(8'h08, 32'd4);
        rd(8'h10, 32'd0);
        wr_div(32'd9, 4'h3);
        rd(8'h08, 32'd4);
        bus_op(BASE | 32'h4, 4'hF, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0);
        rd_status();

        // randomized mix of register traffic, RX frames and TX frames
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 6))
                0: begin
                    v = 32'($urandom_range(0, 20));
                    s = ($urandom_range(0, 3) != 0) ? 4'hF : 4'($urandom_range(0, 15));
                    wr_div(v, s);
                end
                1: rd(8'h08, m_div);
                2: rd_status();
                3: rd_data();
                4: send_rx(8'($urandom), $urandom_range(0, 4) != 0);
                5: begin
                    wr_tx(8'($urandom));
                    wait_tx_idle();
                end
                default: begin
                    case ($urandom_range(0, 2))
                        0: off = 8'h0C;
                        1: off = 8'h10;
                        default: off = 8'hFC;
                    endcase
                    rd(off, 32'd0);
                end
            endcase
        end

        wait_tx_idle();
        repeat (5) @(posedge clk);
        check(bus_q.size() == 0, "bus_queue_drained", bus_q.size(), 32'd0);
        check(tx_q.size() == 0, "tx_queue_drained", tx_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
